// File: rtl/des_cbc_sequencer.sv
// CBC-mode block sequencer around an external DES core (combinational or fixed-latency pipelined).
// Owns the chaining register, the in/out valid-ready handshakes and the core latency counter.
module des_cbc_sequencer #(
    parameter int DES_LAT = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [63:0]      key_i,
    input  logic [63:0]      iv_i,
    input  logic             in_valid_i,
    input  logic [63:0]      in_data_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [63:0]      out_data_o,
    output logic             out_last_o,
    input  logic             out_ready_i,
    output logic [63:0]      des_in_o,
    output logic [63:0]      des_key_o,
    output logic             des_decrypt_o,
    input  logic [63:0]      des_out_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] blk_count_o
);
    localparam int LW = (DES_LAT < 1) ? 1 : $clog2(DES_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_IN, CORE, OUT} state_t;

    state_t            state_q, state_d;
    logic [63:0]       chain_q, chain_d;
    logic [63:0]       cin_q, cin_d;
    logic [63:0]       des_in_q, des_in_d;
    logic [63:0]       des_key_q, des_key_d;
    logic              des_dec_q, des_dec_d;
    logic              last_q, last_d;
    logic [63:0]       out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [LW-1:0]     lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;

    always_comb begin
        state_d    = state_q;
        chain_d    = chain_q;
        cin_d      = cin_q;
        des_in_d   = des_in_q;
        des_key_d  = des_key_q;
        des_dec_d  = des_dec_q;
        last_d     = last_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        lat_cnt_d  = lat_cnt_q;
        blk_cnt_d  = blk_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    des_key_d = key_i;
                    des_dec_d = mode_i;
                    chain_d   = iv_i;
                    blk_cnt_d = '0;
                    state_d   = WAIT_IN;
                end
            end
            WAIT_IN: begin
                if (in_valid_i) begin
                    // Decrypt needs the raw ciphertext later as the next chaining value.
                    if (des_dec_q) begin
                        des_in_d = in_data_i;
                        cin_d    = in_data_i;
                    end else begin
                        des_in_d = in_data_i ^ chain_q;
                    end
                    last_d    = in_last_i;
                    lat_cnt_d = '0;
                    state_d   = CORE;
                end
            end
            CORE: begin
                if (lat_cnt_q == LW'(DES_LAT)) begin
                    if (des_dec_q) begin
                        out_data_d = des_out_i ^ chain_q;
                        chain_d    = cin_q;
                    end else begin
                        out_data_d = des_out_i;
                        chain_d    = des_out_i;
                    end
                    out_last_d = last_q;
                    state_d    = OUT;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            OUT: begin
                if (out_ready_i) begin
                    blk_cnt_d = blk_cnt_q + 1'b1;
                    state_d   = out_last_q ? IDLE : WAIT_IN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            chain_q    <= '0;
            cin_q      <= '0;
            des_in_q   <= '0;
            des_key_q  <= '0;
            des_dec_q  <= 1'b0;
            last_q     <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            lat_cnt_q  <= '0;
            blk_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            chain_q    <= chain_d;
            cin_q      <= cin_d;
            des_in_q   <= des_in_d;
            des_key_q  <= des_key_d;
            des_dec_q  <= des_dec_d;
            last_q     <= last_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            lat_cnt_q  <= lat_cnt_d;
            blk_cnt_q  <= blk_cnt_d;
        end
    end

    assign in_ready_o    = (state_q == WAIT_IN);
    assign out_valid_o   = (state_q == OUT);
    assign busy_o        = (state_q != IDLE);
    assign out_data_o    = out_data_q;
    assign out_last_o    = out_last_q;
    assign des_in_o      = des_in_q;
    assign des_key_o     = des_key_q;
    assign des_decrypt_o = des_dec_q;
    assign blk_count_o   = blk_cnt_q;

endmodule

// File: tb/tb_des_cbc_sequencer.sv
// Bench: two sequencers (combinational core, 3-cycle core with 3-bit counter) driven by a
// software DES core; results checked against known DES vectors and a textbook CBC model.
module tb_des_cbc_sequencer;
    localparam int IP_T[64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                                64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                                61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T[64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
                                37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T[48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                               16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T[32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int PC1_T[56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                 19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T[48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SH_T[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int S_T[512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;

    function automatic logic [63:0] des_blk(input logic [63:0] blk, input logic [63:0] k, input logic dec);
        logic [55:0] cd;
        logic [27:0] c, dd;
        logic [47:0] sk[16];
        logic [47:0] e;
        logic [63:0] x, y;
        logic [31:0] l, r, t, s, f;
        logic [5:0]  b;
        for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_T[i]];
        c = cd[55:28]; dd = cd[27:0];
        for (int n = 0; n < 16; n++) begin
            for (int m = 0; m < SH_T[n]; m++) begin
                c  = {c[26:0], c[27]};
                dd = {dd[26:0], dd[27]};
            end
            cd = {c, dd};
            for (int i = 0; i < 48; i++) sk[n][47-i] = cd[56-PC2_T[i]];
        end
        for (int i = 0; i < 64; i++) x[63-i] = blk[64-IP_T[i]];
        l = x[63:32]; r = x[31:0];
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
            e = e ^ sk[dec ? 15-n : n];
            for (int j = 0; j < 8; j++) begin
                b = e[47-6*j -: 6];
                s[31-4*j -: 4] = 4'(S_T[j*64 + int'({b[5], b[0]})*16 + int'(b[4:1])]);
            end
            for (int i = 0; i < 32; i++) f[31-i] = s[32-P_T[i]];
            t = r; r = l ^ f; l = t;
        end
        x = {r, l};
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic int lat_of(input int d); return (d == 0) ? 0 : 3; endfunction
    function automatic int cw_of(input int d);  return (d == 0) ? 16 : 3; endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst[2], start[2], mode[2], in_valid[2], in_last[2], out_ready[2];
    logic [63:0] key[2], iv[2], in_data[2];
    logic        in_ready[2], out_valid[2], out_last[2], des_dec[2], busy[2];
    logic [63:0] out_data[2], des_in[2], des_key[2], des_out[2];
    logic [15:0] blk_count[2];

    for (genvar g = 0; g < 2; g++) begin : G
        localparam int LAT = (g == 0) ? 0 : 3;
        localparam int CW  = (g == 0) ? 16 : 3;
        logic [CW-1:0] bc;
        logic [63:0]   core_f;
        logic [63:0]   pipe[4];
        des_cbc_sequencer #(.DES_LAT(LAT), .CNT_W(CW)) dut (
            .clk_i(clk), .rst_i(rst[g]), .start_i(start[g]), .mode_i(mode[g]),
            .key_i(key[g]), .iv_i(iv[g]), .in_valid_i(in_valid[g]), .in_data_i(in_data[g]),
            .in_last_i(in_last[g]), .in_ready_o(in_ready[g]), .out_valid_o(out_valid[g]),
            .out_data_o(out_data[g]), .out_last_o(out_last[g]), .out_ready_i(out_ready[g]),
            .des_in_o(des_in[g]), .des_key_o(des_key[g]), .des_decrypt_o(des_dec[g]),
            .des_out_i(des_out[g]), .busy_o(busy[g]), .blk_count_o(bc));
        assign core_f = des_blk(des_in[g], des_key[g], des_dec[g]);
        always @(posedge clk) begin
            pipe[0] <= core_f;
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign des_out[g]   = (LAT == 0) ? core_f : pipe[(LAT == 0) ? 0 : LAT-1];
        assign blk_count[g] = 16'(bc);
    end

    int n_cmp = 0, n_bad = 0;
    logic [63:0] src_q[$], exp_q[$], got_q[$], pt2[$], ct2[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic build_exp(input logic md, input logic [63:0] k, input logic [63:0] v);
        logic [63:0] ch;
        ch = v;
        exp_q.delete();
        foreach (src_q[i]) begin
            if (!md) begin
                ch = des_blk(src_q[i] ^ ch, k, 1'b0);
                exp_q.push_back(ch);
            end else begin
                exp_q.push_back(des_blk(src_q[i], k, 1'b1) ^ ch);
                ch = src_q[i];
            end
        end
    endtask

    function automatic logic [255:0] snap(input int d);
        return 256'({busy[d], in_ready[d], out_valid[d], out_last[d], des_dec[d],
                     out_data[d], des_in[d], des_key[d], blk_count[d]});
    endfunction

    // Streams src_q through instance d with random source gaps / sink stalls, compares to exp_q.
    task automatic run_msg(input int d, input logic md, input logic [63:0] k, input logic [63:0] v,
                           input int gap, input int bp, input bit smid, input string nm, output int cyc);
        int n, sent, recv;
        bit ovl, lastbad, unstable, hold, acc, take;
        logic [63:0] hd;
        n = src_q.size(); sent = 0; recv = 0; cyc = 0;
        ovl = 0; lastbad = 0; unstable = 0; hold = 0; hd = '0;
        got_q.delete();
        @(negedge clk); start[d] = 1'b1; mode[d] = md; key[d] = k; iv[d] = v;
        @(negedge clk); start[d] = 1'b0; mode[d] = ~md; key[d] = {$urandom, $urandom}; iv[d] = {$urandom, $urandom};
        while (recv < n && cyc < 4000) begin
            if (!in_valid[d] && sent < n && $urandom_range(99) >= gap) begin
                in_valid[d] = 1'b1; in_data[d] = src_q[sent]; in_last[d] = (sent == n-1);
            end
            out_ready[d] = ($urandom_range(99) >= bp);
            start[d] = smid && (cyc == 4);
            if (hold && (out_data[d] !== hd || out_valid[d] !== 1'b1)) unstable = 1;
            hold = out_valid[d] && !out_ready[d]; hd = out_data[d];
            if (in_ready[d] && out_valid[d]) ovl = 1;
            acc  = in_valid[d] && in_ready[d];
            take = out_valid[d] && out_ready[d];
            if (take) begin
                got_q.push_back(out_data[d]);
                if (out_last[d] !== (recv == n-1)) lastbad = 1;
            end
            @(posedge clk);
            if (acc) sent++;
            if (take) recv++;
            cyc++;
            @(negedge clk);
            if (acc) in_valid[d] = 1'b0;
        end
        in_valid[d] = 1'b0; out_ready[d] = 1'b0; start[d] = 1'b0;
        chk($sformatf("%s blocks delivered", nm), 256'(recv), 256'(n));
        for (int i = 0; i < n; i++)
            chk($sformatf("%s out_data[%0d]", nm, i), (i < got_q.size()) ? got_q[i] : 64'hx, exp_q[i]);
        chk($sformatf("%s out_last flags", nm), 256'(lastbad), 256'(0));
        chk($sformatf("%s in_ready/out_valid overlap", nm), 256'(ovl), 256'(0));
        chk($sformatf("%s stall stability", nm), 256'(unstable), 256'(0));
        chk($sformatf("%s busy after last", nm), 256'(busy[d]), 256'(0));
        chk($sformatf("%s blk_count", nm), 256'(blk_count[d]), 256'(n % (1 << cw_of(d))));
    endtask

    task automatic wait_ov(input int d, output int k);
        k = 1;
        @(negedge clk);
        in_valid[d] = 1'b0;
        while (!out_valid[d] && k < 20) begin
            @(posedge clk); k++; @(negedge clk);
        end
    endtask

    // Hand sequence: exact accept-to-out_valid latency, 5-cycle stall, second block held at source.
    task automatic lat_bp(input int d);
        logic [63:0] b, h, c1;
        int k;
        bit ok;
        b = {$urandom, $urandom};
        @(negedge clk); start[d] = 1'b1; mode[d] = 1'b0; key[d] = K1; iv[d] = '0;
        @(negedge clk); start[d] = 1'b0; in_valid[d] = 1'b1; in_data[d] = 64'h0123456789ABCDEF;
        in_last[d] = 1'b0; out_ready[d] = 1'b0;
        chk($sformatf("lat%0d in_ready", d), 256'(in_ready[d]), 256'(1));
        @(posedge clk);
        k = 1;
        @(negedge clk); in_data[d] = b; in_last[d] = 1'b1;
        while (!out_valid[d] && k < 20) begin
            @(posedge clk); k++; @(negedge clk);
        end
        chk($sformatf("lat%0d first out_valid edge", d), 256'(k), 256'(2 + lat_of(d)));
        ok = 1; h = out_data[d];
        repeat (5) begin
            @(posedge clk); @(negedge clk);
            if (out_data[d] !== h || out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0) ok = 0;
        end
        chk($sformatf("lat%0d stall hold", d), 256'(ok), 256'(1));
        chk($sformatf("lat%0d block0", d), 256'(h), 256'(64'h85E813540F0AB405));
        out_ready[d] = 1'b1;
        @(posedge clk); @(negedge clk); out_ready[d] = 1'b0;
        chk($sformatf("lat%0d in_ready after out", d), 256'(in_ready[d]), 256'(1));
        @(posedge clk);
        wait_ov(d, k);
        chk($sformatf("lat%0d second out_valid edge", d), 256'(k), 256'(2 + lat_of(d)));
        c1 = des_blk(b ^ 64'h85E813540F0AB405, K1, 1'b0);
        chk($sformatf("lat%0d block1", d), 256'(out_data[d]), 256'(c1));
        chk($sformatf("lat%0d out_last", d), 256'(out_last[d]), 256'(1));
        out_ready[d] = 1'b1;
        @(posedge clk); @(negedge clk); out_ready[d] = 1'b0;
        chk($sformatf("lat%0d busy", d), 256'(busy[d]), 256'(0));
        chk($sformatf("lat%0d blk_count", d), 256'(blk_count[d]), 256'(2));
    endtask

    // Hand sequence: reset while block 3 is in the core.
    task automatic rst_mid(input int d);
        int cnt, c;
        bit acc, ok;
        @(negedge clk); start[d] = 1'b1; mode[d] = 1'b0; key[d] = K1; iv[d] = K1;
        @(negedge clk); start[d] = 1'b0;
        cnt = 0; c = 0;
        while (cnt < 3 && c < 200) begin
            in_valid[d] = 1'b1; in_data[d] = pt2[cnt]; in_last[d] = 1'b0; out_ready[d] = 1'b1;
            acc = in_ready[d];
            @(posedge clk);
            if (acc) cnt++;
            c++;
            @(negedge clk);
        end
        in_valid[d] = 1'b0; out_ready[d] = 1'b0;
        chk("rst reached block 3", 256'(cnt), 256'(3));
        rst[d] = 1'b1;
        @(posedge clk); @(negedge clk); rst[d] = 1'b0;
        chk("rst mid outputs", snap(d), 256'(0));
        ok = 1; out_ready[d] = 1'b1;
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0) ok = 0;
        end
        out_ready[d] = 1'b0;
        chk("rst no abandoned output", 256'(ok), 256'(1));
    endtask

    typedef struct {
        logic        md;
        logic [63:0] k;
        logic [63:0] v;
        logic [63:0] din;
        logic [63:0] dout;
    } vec_t;

    initial begin
        vec_t tv[6];
        int   cyc, d, n;
        logic md;
        logic [63:0] k, v;
        tv[0] = '{1'b0, K1, 64'h0, 64'h0123456789ABCDEF, 64'h85E813540F0AB405};
        tv[1] = '{1'b1, K1, 64'h0, 64'h85E813540F0AB405, 64'h0123456789ABCDEF};
        tv[2] = '{1'b0, K1, 64'hFFFFFFFFFFFFFFFF, 64'hFEDCBA9876543210, 64'h85E813540F0AB405};
        tv[3] = '{1'b1, K1, 64'hFFFFFFFFFFFFFFFF, 64'h85E813540F0AB405, 64'hFEDCBA9876543210};
        tv[4] = '{1'b0, K2, 64'h0, 64'h8787878787878787, 64'h0000000000000000};
        tv[5] = '{1'b1, K2, 64'h0, 64'h0000000000000000, 64'h8787878787878787};
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; mode[i] = 1'b0; in_valid[i] = 1'b0; in_last[i] = 1'b0;
            out_ready[i] = 1'b0; key[i] = '0; iv[i] = '0; in_data[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) chk($sformatf("reset state inst%0d", i), snap(i), 256'(0));
        rst[0] = 1'b0; rst[1] = 1'b0;

        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 6; j++) begin
                src_q.delete(); src_q.push_back(tv[j].din);
                exp_q.delete(); exp_q.push_back(tv[j].dout);
                run_msg(i, tv[j].md, tv[j].k, tv[j].v, 0, 50, 1'b0, $sformatf("vec%0d inst%0d", j, i), cyc);
            end

        pt2.delete();
        for (int i = 0; i < 8; i++) pt2.push_back({$urandom, $urandom});
        src_q = pt2; build_exp(1'b0, K1, K1); ct2 = exp_q;
        run_msg(0, 1'b0, K1, K1, 0, 0, 1'b0, "cbc enc", cyc);
        chk("cbc enc cycles", 256'(cyc), 256'(8 * 3));

        src_q = ct2; exp_q = pt2;
        run_msg(0, 1'b1, K1, K1, 30, 30, 1'b0, "cbc dec", cyc);

        src_q = pt2; exp_q = ct2;
        run_msg(0, 1'b0, K1, K1, 50, 60, 1'b0, "cbc gaps", cyc);
        lat_bp(0);
        lat_bp(1);

        src_q = pt2; exp_q = ct2;
        run_msg(1, 1'b0, K1, K1, 0, 0, 1'b1, "lat3 start-ignored", cyc);
        chk("lat3 cycles", 256'(cyc), 256'(8 * 6));
        src_q = ct2; exp_q = pt2;
        run_msg(0, 1'b1, K1, K1, 20, 20, 1'b1, "lat0 dec start-ignored", cyc);

        rst_mid(1);
        src_q = pt2; exp_q = ct2;
        run_msg(1, 1'b0, K1, K1, 0, 0, 1'b0, "after rst", cyc);

        src_q.delete();
        for (int i = 0; i < 9; i++) src_q.push_back({$urandom, $urandom});
        build_exp(1'b0, K2, 64'h5A5A5A5AA5A5A5A5);
        run_msg(1, 1'b0, K2, 64'h5A5A5A5AA5A5A5A5, 10, 10, 1'b0, "count wrap", cyc);

        for (int r = 0; r < 6; r++) begin
            d  = int'($urandom_range(1));
            md = 1'($urandom_range(1));
            k  = {$urandom, $urandom};
            v  = {$urandom, $urandom};
            n  = int'($urandom_range(6, 1));
            src_q.delete();
            for (int i = 0; i < n; i++) src_q.push_back({$urandom, $urandom});
            build_exp(md, k, v);
            run_msg(d, md, k, v, 40, 40, n >= 2, $sformatf("rand%0d", r), cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
